mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one 4:1 mux datapath among 4 requesters.

---
 rtl/mux4_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin grant of one shared 4:1 mux, with a per-grant hold limit.
// Optional LOCK_EN macro adds a lock input that suspends the hold limit while granted.
module mux4_rr_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] din,
`ifdef LOCK_EN
  input  logic           lock,
`endif
  output logic [3:0]     gnt,
  output logic [1:0]     sel,
  output logic           busy,
  output logic [W-1:0]   dout,
  output logic           dout_valid,
  output logic [1:0]     dout_src
);

  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    sel_nxt;
  logic [1:0]    ptr;
  logic [1:0]    ptr_nxt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_nxt;
  logic [3:0]    gnt_d;
  logic [3:0]    masked;
  logic [2:0]    pk_idle;
  logic [2:0]    pk_rel;
  logic          lock_on;
  logic          limit;
  logic          release_g;

`ifdef LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  // {found, index} of the first set bit of r, searching p, p+1, ... mod 4
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign busy    = (state == GRANT);
  assign limit   = (hold_cnt == HOLD_LAST) && !lock_on;
  assign release_g = !req[sel] || limit;
  assign masked  = req & ~gnt;
  assign pk_idle = pick(req, ptr);
  assign pk_rel  = pick(masked, sel + 2'd1);

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (pk_idle[2]) begin
          state_nxt = GRANT;
          sel_nxt   = pk_idle[1:0];
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (release_g) begin
          ptr_nxt  = sel + 2'd1;
          hold_nxt = '0;
          if (pk_rel[2]) begin
            sel_nxt = pk_rel[1:0];
          end else if (!req[sel]) begin
            state_nxt = IDLE;
          end
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    gnt_d = '0;
    if (state_nxt == GRANT) gnt_d[sel_nxt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_d;
    end
  end

  // dout keeps its last value whenever no lane was granted
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_src   <= '0;
    end else begin
      dout_valid <= busy;
      if (busy) begin
        dout     <= din[int'(sel)*W +: W];
        dout_src <= sel;
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: vector table, directed sequences and random run
// against a reference model, on MAX_HOLD=8 and MAX_HOLD=1 instances.
module tb_mux4_rr_arbiter;

  localparam int W = 8;
`ifdef LOCK_EN
  localparam bit HAS_LOCK = 1'b1;
`else
  localparam bit HAS_LOCK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           lock = 1'b0;
  logic [3:0]     req = 4'hF;
  logic [4*W-1:0] din = 32'h44332211;

  logic [3:0]   gnt0, gnt1;
  logic [1:0]   sel0, sel1, src0, src1;
  logic         busy0, busy1, val0, val1;
  logic [W-1:0] dout0, dout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.W(W), .MAX_HOLD(8)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .din(din),
`ifdef LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt0), .sel(sel0), .busy(busy0),
    .dout(dout0), .dout_valid(val0), .dout_src(src0)
  );

  mux4_rr_arbiter #(.W(W), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .din(din),
`ifdef LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt1), .sel(sel1), .busy(busy1),
    .dout(dout1), .dout_valid(val1), .dout_src(src1)
  );

  // g = granted lane or -1 when idle; cnt = cycles already spent in this grant
  typedef struct {
    int g;
    int cnt;
    int ptr;
    int sel;
    int dout;
    int dsrc;
    int dval;
  } mdl_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       val;
    logic [7:0] dout;
  } vec_t;

  mdl_t m0, m1;
  vec_t tbl[7];
  int   lanes[5];

  function automatic mdl_t mreset();
    mdl_t n;
    n = '{default: 0};
    n.g = -1;
    return n;
  endfunction

  function automatic int first(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int mh, input logic r,
                                 input logic [3:0] rq, input logic lk,
                                 input logic [31:0] d);
    mdl_t n;
    logic [3:0] others;
    if (r) return mreset();
    n = m;
    n.dval = (m.g >= 0) ? 1 : 0;
    if (m.g >= 0) begin
      n.dout = int'(d[m.sel*8 +: 8]);
      n.dsrc = m.sel;
    end
    if (m.g < 0) begin
      if (rq != 4'b0) begin
        n.g = first(rq, m.ptr);
        n.cnt = 0;
      end
    end else if (!rq[m.g] || (m.cnt >= mh - 1 && !lk)) begin
      n.ptr = (m.g + 1) % 4;
      n.cnt = 0;
      others = rq;
      others[m.g] = 1'b0;
      if (others != 4'b0) n.g = first(others, n.ptr);
      else if (!rq[m.g]) n.g = -1;
    end else begin
      n.cnt = m.cnt + 1;
    end
    if (n.g >= 0) n.sel = n.g;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string p, input mdl_t m, input logic [3:0] g,
                     input logic [1:0] s, input logic b, input logic [7:0] d,
                     input logic v, input logic [1:0] src);
    logic [31:0] eg;
    eg = (m.g >= 0) ? (32'd1 << m.g) : 32'd0;
    chk({p, ".gnt"}, {28'd0, g}, eg);
    chk({p, ".sel"}, {30'd0, s}, 32'(m.sel));
    chk({p, ".busy"}, {31'd0, b}, (m.g >= 0) ? 32'd1 : 32'd0);
    chk({p, ".dout"}, {24'd0, d}, 32'(m.dout));
    chk({p, ".dval"}, {31'd0, v}, 32'(m.dval));
    chk({p, ".dsrc"}, {30'd0, src}, 32'(m.dsrc));
  endtask

  task automatic step();
    logic lk;
    lk = HAS_LOCK && lock;
    @(posedge clk);
    m0 = mstep(m0, 8, rst, req, lk, din);
    m1 = mstep(m1, 1, rst, req, lk, din);
    #1;
    cmp("h8", m0, gnt0, sel0, busy0, dout0, val0, src0);
    cmp("h1", m1, gnt1, sel1, busy1, dout1, val1, src1);
  endtask

  initial begin
    m0 = mreset();
    m1 = mreset();
    tbl[0] = '{1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 4'h4, 4'h4, 2'd2, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 8'h33};
    tbl[4] = '{1'b0, 4'h4, 4'h4, 2'd2, 1'b1, 1'b1, 8'h33};
    tbl[5] = '{1'b0, 4'h0, 4'h0, 2'd2, 1'b0, 1'b1, 8'h33};
    tbl[6] = '{1'b0, 4'h0, 4'h0, 2'd2, 1'b0, 1'b0, 8'h33};
    lanes = '{0, 1, 2, 3, 0};

    for (int i = 0; i < 7; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      step();
      chk("tbl.gnt", {28'd0, gnt0}, {28'd0, tbl[i].gnt});
      chk("tbl.sel", {30'd0, sel0}, {30'd0, tbl[i].sel});
      chk("tbl.busy", {31'd0, busy0}, {31'd0, tbl[i].busy});
      chk("tbl.dval", {31'd0, val0}, {31'd0, tbl[i].val});
      chk("tbl.dout", {24'd0, dout0}, {24'd0, tbl[i].dout});
    end

    // full request: 8-cycle turns rotating 0,1,2,3,0 with no gaps
    rst = 1'b1; req = 4'hF; step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 8; k++) begin
        step();
        chk("rot.gnt", {28'd0, gnt0}, 32'd1 << lanes[i]);
        chk("rot.busy", {31'd0, busy0}, 32'd1);
      end

    // lone requester survives hold-limit re-grants
    rst = 1'b1; req = 4'h0; step();
    rst = 1'b0; req = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("solo.gnt", {28'd0, gnt0}, 32'h2);
      chk("solo.busy", {31'd0, busy0}, 32'd1);
    end
    req = 4'h0; step();
    chk("solo.idle", {28'd0, gnt0}, 32'h0);

    // pointer wraps from lane 3 to lane 0
    rst = 1'b1; step();
    rst = 1'b0; req = 4'b0100; step();
    req = 4'b0000; step();
    req = 4'b1000; step();
    chk("wrap.g3", {28'd0, gnt0}, 32'h8);
    req = 4'b1001; step();
    chk("wrap.hold3", {28'd0, gnt0}, 32'h8);
    req = 4'b0011; step();
    chk("wrap.g0", {28'd0, gnt0}, 32'h1);
    chk("wrap.sel", {30'd0, sel0}, 32'd0);

`ifdef LOCK_EN
    rst = 1'b1; req = 4'h0; step();
    rst = 1'b0; req = 4'b0100; step();
    lock = 1'b1; req = 4'hF;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("lock.gnt", {28'd0, gnt0}, 32'h4);
    end
    lock = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        step();
        if (gnt0 == 4'b1000) seen = 1'b1;
      end
      chk("lock.resume", {31'd0, seen}, 32'd1);
    end
`endif

    // random traffic against the reference model
    lock = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      din = $urandom();
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) lock = ~lock;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
